// File: rtl/sc_psr_window_if.sv
// Command/flag/status bundle between the ALU/decode side and the PSR/window block.
// The master drives commands and flags. The slave returns the PSR state and event pulses.
interface sc_psr_window_if #(
  parameter int DATAWIDTH_ICC = 4,
  parameter int NWINDOWS      = 8,
  parameter int DATAWIDTH_CWP = 5,
  parameter int DATAWIDTH_BUS = 32
);
  logic                     SC_PsrWin_negativo;
  logic                     SC_PsrWin_cero;
  logic                     SC_PsrWin_overflow;
  logic                     SC_PsrWin_carry;
  logic                     SC_PsrWin_WriteIcc_InLow;
  logic                     SC_PsrWin_Save_InLow;
  logic                     SC_PsrWin_Restore_InLow;
  logic                     SC_PsrWin_Trap_InLow;
  logic                     SC_PsrWin_Rett_InLow;
  logic                     SC_PsrWin_WritePsr_InLow;
  logic [DATAWIDTH_BUS-1:0] SC_PsrWin_Data_In;
  logic [NWINDOWS-1:0]      SC_PsrWin_Wim_In;
  logic [DATAWIDTH_ICC-1:0] SC_PsrWin_Icc_Out;
  logic [DATAWIDTH_CWP-1:0] SC_PsrWin_Cwp_Out;
  logic                     SC_PsrWin_S_Out;
  logic                     SC_PsrWin_PS_Out;
  logic                     SC_PsrWin_ET_Out;
  logic [DATAWIDTH_BUS-1:0] SC_PsrWin_Psr_Out;
  logic                     SC_PsrWin_WinOverflow_Out;
  logic                     SC_PsrWin_WinUnderflow_Out;
  logic                     SC_PsrWin_Illegal_Out;
  logic                     SC_PsrWin_ErrorMode_Out;

  modport master (
    output SC_PsrWin_negativo, SC_PsrWin_cero, SC_PsrWin_overflow, SC_PsrWin_carry,
           SC_PsrWin_WriteIcc_InLow, SC_PsrWin_Save_InLow, SC_PsrWin_Restore_InLow,
           SC_PsrWin_Trap_InLow, SC_PsrWin_Rett_InLow, SC_PsrWin_WritePsr_InLow,
           SC_PsrWin_Data_In, SC_PsrWin_Wim_In,
    input  SC_PsrWin_Icc_Out, SC_PsrWin_Cwp_Out, SC_PsrWin_S_Out, SC_PsrWin_PS_Out,
           SC_PsrWin_ET_Out, SC_PsrWin_Psr_Out, SC_PsrWin_WinOverflow_Out,
           SC_PsrWin_WinUnderflow_Out, SC_PsrWin_Illegal_Out, SC_PsrWin_ErrorMode_Out
  );

  modport slave (
    input  SC_PsrWin_negativo, SC_PsrWin_cero, SC_PsrWin_overflow, SC_PsrWin_carry,
           SC_PsrWin_WriteIcc_InLow, SC_PsrWin_Save_InLow, SC_PsrWin_Restore_InLow,
           SC_PsrWin_Trap_InLow, SC_PsrWin_Rett_InLow, SC_PsrWin_WritePsr_InLow,
           SC_PsrWin_Data_In, SC_PsrWin_Wim_In,
    output SC_PsrWin_Icc_Out, SC_PsrWin_Cwp_Out, SC_PsrWin_S_Out, SC_PsrWin_PS_Out,
           SC_PsrWin_ET_Out, SC_PsrWin_Psr_Out, SC_PsrWin_WinOverflow_Out,
           SC_PsrWin_WinUnderflow_Out, SC_PsrWin_Illegal_Out, SC_PsrWin_ErrorMode_Out
  );
endinterface

// File: rtl/sc_psr_window.sv
// Processor status register with register-window pointer, WIM checking and trap/error-mode handling.
// All outputs come straight from registers. Commands act on the edge that samples them.
module sc_psr_window #(
  parameter int DATAWIDTH_ICC = 4,
  parameter int NWINDOWS      = 8,
  parameter int DATAWIDTH_CWP = 5,
  parameter int DATAWIDTH_BUS = 32
)(
  input logic            SC_PsrWin_CLOCK_50,
  input logic            SC_PsrWin_RESET_InLow,
  sc_psr_window_if.slave psr_if
);
  typedef logic [DATAWIDTH_CWP-1:0] cwp_t;
  typedef logic [NWINDOWS-1:0]      wim_t;
  typedef logic [DATAWIDTH_BUS-1:0] bus_t;

  typedef struct packed {
    logic [DATAWIDTH_ICC-1:0] icc;
    logic                     s;
    logic                     ps;
    logic                     et;
    cwp_t                     cwp;
  } psr_t;

  typedef struct packed {
    logic wicc;
    logic save;
    logic rest;
    logic trap;
    logic rett;
    logic wpsr;
  } cmd_t;

  typedef enum logic {ST_RUN, ST_ERR} state_t;

  localparam cwp_t CWP_MAX = cwp_t'(NWINDOWS - 1);
  localparam cwp_t CWP_ONE = cwp_t'(1);
  localparam wim_t WIM_ONE = wim_t'(1);
  localparam psr_t PSR_RST = '{icc: '1, s: 1'b1, ps: 1'b0, et: 1'b0, cwp: '0};

  state_t state_q, state_nxt;
  psr_t   psr_q, psr_nxt;
  logic   ovf_q, unf_q, ill_q;
  logic   ovf_nxt, unf_nxt, ill_nxt;
  cmd_t   cmd;
  bus_t   data;
  wim_t   wim;
  cwp_t   cwp_dec, cwp_inc;
  logic   wim_dec, wim_inc, wr_cwp_bad, icc_ld;
  logic [DATAWIDTH_ICC-1:0] flags;
  bus_t   psr_img;
  logic   unused_bus_bits;

  assign cmd = '{wicc: ~psr_if.SC_PsrWin_WriteIcc_InLow,
                 save: ~psr_if.SC_PsrWin_Save_InLow,
                 rest: ~psr_if.SC_PsrWin_Restore_InLow,
                 trap: ~psr_if.SC_PsrWin_Trap_InLow,
                 rett: ~psr_if.SC_PsrWin_Rett_InLow,
                 wpsr: ~psr_if.SC_PsrWin_WritePsr_InLow};
  assign data  = psr_if.SC_PsrWin_Data_In;
  assign wim   = psr_if.SC_PsrWin_Wim_In;
  assign flags = {psr_if.SC_PsrWin_negativo, psr_if.SC_PsrWin_cero,
                  psr_if.SC_PsrWin_overflow, psr_if.SC_PsrWin_carry};

  // Window neighbours wrap modulo NWINDOWS, not modulo 2^DATAWIDTH_CWP.
  assign cwp_dec    = (psr_q.cwp == '0)     ? CWP_MAX : psr_q.cwp - CWP_ONE;
  assign cwp_inc    = (psr_q.cwp == CWP_MAX) ? '0      : psr_q.cwp + CWP_ONE;
  assign wim_dec    = |(wim & (WIM_ONE << cwp_dec));
  assign wim_inc    = |(wim & (WIM_ONE << cwp_inc));
  assign wr_cwp_bad = ({1'b0, data[4:0]} >= 6'(NWINDOWS));
  assign unused_bus_bits = ^{data[DATAWIDTH_BUS-1:24], data[19:8]};

  always_ff @(posedge SC_PsrWin_CLOCK_50 or negedge SC_PsrWin_RESET_InLow) begin
    if (!SC_PsrWin_RESET_InLow) state_q <= ST_RUN;
    else                        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    psr_nxt   = psr_q;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    ill_nxt   = 1'b0;
    icc_ld    = cmd.wicc;
    if (state_q == ST_RUN) begin
      if (cmd.trap) begin
        if (psr_q.et) begin
          psr_nxt.et  = 1'b0;
          psr_nxt.ps  = psr_q.s;
          psr_nxt.s   = 1'b1;
          psr_nxt.cwp = cwp_dec;
        end else begin
          state_nxt = ST_ERR;
        end
      end else if (cmd.wpsr) begin
        if (!psr_q.s || wr_cwp_bad) begin
          ill_nxt = 1'b1;
        end else begin
          psr_nxt.icc = data[23:20];
          psr_nxt.s   = data[7];
          psr_nxt.ps  = data[6];
          psr_nxt.et  = data[5];
          psr_nxt.cwp = cwp_t'(data[4:0]);
          icc_ld      = 1'b0;
        end
      end else if (cmd.rett) begin
        if (psr_q.et || !psr_q.s) begin
          ill_nxt = 1'b1;
        end else if (wim_inc) begin
          unf_nxt = 1'b1;
        end else begin
          psr_nxt.et  = 1'b1;
          psr_nxt.s   = psr_q.ps;
          psr_nxt.cwp = cwp_inc;
        end
      end else if (cmd.save && !cmd.rest) begin
        if (wim_dec) ovf_nxt = 1'b1;
        else         psr_nxt.cwp = cwp_dec;
      end else if (cmd.rest && !cmd.save) begin
        if (wim_inc) unf_nxt = 1'b1;
        else         psr_nxt.cwp = cwp_inc;
      end
    end
    // Flag loads run beside the command path; only an accepted PSR write overrides them.
    if (icc_ld) psr_nxt.icc = flags;
  end

  always_ff @(posedge SC_PsrWin_CLOCK_50 or negedge SC_PsrWin_RESET_InLow) begin
    if (!SC_PsrWin_RESET_InLow) begin
      psr_q <= PSR_RST;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      psr_q <= psr_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
      ill_q <= ill_nxt;
    end
  end

  always_comb begin
    psr_img        = '0;
    psr_img[23:20] = psr_q.icc;
    psr_img[7]     = psr_q.s;
    psr_img[6]     = psr_q.ps;
    psr_img[5]     = psr_q.et;
    psr_img[4:0]   = 5'(psr_q.cwp);
  end

  assign psr_if.SC_PsrWin_Icc_Out          = psr_q.icc;
  assign psr_if.SC_PsrWin_Cwp_Out          = psr_q.cwp;
  assign psr_if.SC_PsrWin_S_Out            = psr_q.s;
  assign psr_if.SC_PsrWin_PS_Out           = psr_q.ps;
  assign psr_if.SC_PsrWin_ET_Out           = psr_q.et;
  assign psr_if.SC_PsrWin_Psr_Out          = psr_img;
  assign psr_if.SC_PsrWin_WinOverflow_Out  = ovf_q;
  assign psr_if.SC_PsrWin_WinUnderflow_Out = unf_q;
  assign psr_if.SC_PsrWin_Illegal_Out      = ill_q;
  assign psr_if.SC_PsrWin_ErrorMode_Out    = (state_q == ST_ERR);
endmodule

// File: tb/tb_sc_psr_window.sv
// Scoreboarded bench for sc_psr_window (NWINDOWS=8): directed scenarios plus a random command stream.
module tb_sc_psr_window;
  localparam logic [5:0] C_WICC = 6'b000001, C_SAVE = 6'b000010, C_REST = 6'b000100,
                         C_TRAP = 6'b001000, C_RETT = 6'b010000, C_WPSR = 6'b100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] psr;
    logic [2:0]  pulses;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [3:0] m_icc;
  logic [4:0] m_cwp;
  logic       m_s, m_ps, m_et, m_err;

  sc_psr_window_if #(.DATAWIDTH_ICC(4), .NWINDOWS(8), .DATAWIDTH_CWP(5), .DATAWIDTH_BUS(32)) psr_if ();

  sc_psr_window #(.DATAWIDTH_ICC(4), .NWINDOWS(8), .DATAWIDTH_CWP(5), .DATAWIDTH_BUS(32)) dut (
    .SC_PsrWin_CLOCK_50   (clk),
    .SC_PsrWin_RESET_InLow(rst_n),
    .psr_if               (psr_if)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end, got timeout, required finish");
    $fatal(1);
  end

  // Pops one expectation per sampled edge and compares every output against it.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (psr_if.SC_PsrWin_Psr_Out !== mon_e.psr) begin
        errors++; $display("FAIL sb_psr got=%h exp=%h", psr_if.SC_PsrWin_Psr_Out, mon_e.psr);
      end
      checks++;
      if ({psr_if.SC_PsrWin_Icc_Out, psr_if.SC_PsrWin_S_Out, psr_if.SC_PsrWin_PS_Out,
           psr_if.SC_PsrWin_ET_Out, psr_if.SC_PsrWin_Cwp_Out} !==
          {mon_e.psr[23:20], mon_e.psr[7:5], mon_e.psr[4:0]}) begin
        errors++; $display("FAIL sb_fields icc=%h s=%b ps=%b et=%b cwp=%0d exp_psr=%h",
          psr_if.SC_PsrWin_Icc_Out, psr_if.SC_PsrWin_S_Out, psr_if.SC_PsrWin_PS_Out,
          psr_if.SC_PsrWin_ET_Out, psr_if.SC_PsrWin_Cwp_Out, mon_e.psr);
      end
      checks++;
      if ({psr_if.SC_PsrWin_WinOverflow_Out, psr_if.SC_PsrWin_WinUnderflow_Out,
           psr_if.SC_PsrWin_Illegal_Out} !== mon_e.pulses) begin
        errors++; $display("FAIL sb_pulses ovf/unf/ill got=%b exp=%b",
          {psr_if.SC_PsrWin_WinOverflow_Out, psr_if.SC_PsrWin_WinUnderflow_Out,
           psr_if.SC_PsrWin_Illegal_Out}, mon_e.pulses);
      end
      checks++;
      if (psr_if.SC_PsrWin_ErrorMode_Out !== mon_e.err) begin
        errors++; $display("FAIL sb_errmode got=%b exp=%b", psr_if.SC_PsrWin_ErrorMode_Out, mon_e.err);
      end
    end
  end

  task automatic model_reset();
    m_icc = 4'hF; m_cwp = 5'd0; m_s = 1'b1; m_ps = 1'b0; m_et = 1'b0; m_err = 1'b0;
    sb.delete();
  endtask

  task automatic drive_idle();
    psr_if.SC_PsrWin_WriteIcc_InLow = 1'b1;
    psr_if.SC_PsrWin_Save_InLow     = 1'b1;
    psr_if.SC_PsrWin_Restore_InLow  = 1'b1;
    psr_if.SC_PsrWin_Trap_InLow     = 1'b1;
    psr_if.SC_PsrWin_Rett_InLow     = 1'b1;
    psr_if.SC_PsrWin_WritePsr_InLow = 1'b1;
    psr_if.SC_PsrWin_Data_In        = 32'h0;
    psr_if.SC_PsrWin_Wim_In         = 8'h0;
    {psr_if.SC_PsrWin_negativo, psr_if.SC_PsrWin_cero,
     psr_if.SC_PsrWin_overflow, psr_if.SC_PsrWin_carry} = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one cycle of commands, advances the reference model and queues its prediction.
  task automatic step(input logic [5:0] cmd, input logic [31:0] data = 32'h0,
                      input logic [7:0] wim = 8'h0, input logic [3:0] fl = 4'h0);
    exp_t e;
    logic [4:0] up, dn;
    logic o, u, il, icc_ok;
    @(negedge clk);
    psr_if.SC_PsrWin_WriteIcc_InLow = ~cmd[0];
    psr_if.SC_PsrWin_Save_InLow     = ~cmd[1];
    psr_if.SC_PsrWin_Restore_InLow  = ~cmd[2];
    psr_if.SC_PsrWin_Trap_InLow     = ~cmd[3];
    psr_if.SC_PsrWin_Rett_InLow     = ~cmd[4];
    psr_if.SC_PsrWin_WritePsr_InLow = ~cmd[5];
    psr_if.SC_PsrWin_Data_In        = data;
    psr_if.SC_PsrWin_Wim_In         = wim;
    {psr_if.SC_PsrWin_negativo, psr_if.SC_PsrWin_cero,
     psr_if.SC_PsrWin_overflow, psr_if.SC_PsrWin_carry} = fl;
    o = 1'b0; u = 1'b0; il = 1'b0; icc_ok = cmd[0];
    dn = (m_cwp == 5'd0) ? 5'd7 : m_cwp - 5'd1;
    up = (m_cwp == 5'd7) ? 5'd0 : m_cwp + 5'd1;
    if (!m_err) begin
      if (cmd[3]) begin
        if (m_et) begin m_ps = m_s; m_s = 1'b1; m_et = 1'b0; m_cwp = dn; end
        else m_err = 1'b1;
      end else if (cmd[5]) begin
        if (!m_s || data[4:0] > 5'd7) il = 1'b1;
        else begin
          m_icc = data[23:20]; m_s = data[7]; m_ps = data[6]; m_et = data[5];
          m_cwp = data[4:0]; icc_ok = 1'b0;
        end
      end else if (cmd[4]) begin
        if (m_et || !m_s) il = 1'b1;
        else if (wim[up[2:0]]) u = 1'b1;
        else begin m_et = 1'b1; m_s = m_ps; m_cwp = up; end
      end else if (cmd[1] && !cmd[2]) begin
        if (wim[dn[2:0]]) o = 1'b1; else m_cwp = dn;
      end else if (cmd[2] && !cmd[1]) begin
        if (wim[up[2:0]]) u = 1'b1; else m_cwp = up;
      end
    end
    if (icc_ok) m_icc = fl;
    e.psr    = {8'h00, m_icc, 12'h000, m_s, m_ps, m_et, m_cwp};
    e.pulses = {o, u, il};
    e.err    = m_err;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #25;
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h00F0_0080) begin
      errors++; $display("FAIL reset_psr_in_reset got=%h exp=00f00080", psr_if.SC_PsrWin_Psr_Out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(6'b0);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h00F0_0080) begin
      errors++; $display("FAIL reset_psr got=%h exp=00f00080", psr_if.SC_PsrWin_Psr_Out);
    end
    checks++;
    if (psr_if.SC_PsrWin_Cwp_Out !== 5'd0 || psr_if.SC_PsrWin_ErrorMode_Out !== 1'b0) begin
      errors++; $display("FAIL reset_cwp_err got cwp=%0d err=%b exp cwp=0 err=0",
        psr_if.SC_PsrWin_Cwp_Out, psr_if.SC_PsrWin_ErrorMode_Out);
    end
  endtask

  task automatic test_save_wrap();
    step(C_SAVE);
    checks++;
    if (psr_if.SC_PsrWin_Cwp_Out !== 5'd7) begin
      errors++; $display("FAIL save_wrap got=%0d exp=7", psr_if.SC_PsrWin_Cwp_Out);
    end
    for (int i = 0; i < 8; i++) step(C_REST);
    checks++;
    if (psr_if.SC_PsrWin_Cwp_Out !== 5'd7 || psr_if.SC_PsrWin_WinUnderflow_Out !== 1'b0) begin
      errors++; $display("FAIL restore_loop got cwp=%0d unf=%b exp cwp=7 unf=0",
        psr_if.SC_PsrWin_Cwp_Out, psr_if.SC_PsrWin_WinUnderflow_Out);
    end
  endtask

  task automatic test_overflow();
    step(C_WPSR, 32'h0000_0083);
    step(C_SAVE, 32'h0, 8'b0000_0100);
    checks++;
    if (psr_if.SC_PsrWin_Cwp_Out !== 5'd3 || psr_if.SC_PsrWin_WinOverflow_Out !== 1'b1) begin
      errors++; $display("FAIL overflow got cwp=%0d ovf=%b exp cwp=3 ovf=1",
        psr_if.SC_PsrWin_Cwp_Out, psr_if.SC_PsrWin_WinOverflow_Out);
    end
    step(6'b0);
    checks++;
    if (psr_if.SC_PsrWin_WinOverflow_Out !== 1'b0) begin
      errors++; $display("FAIL overflow_one_cycle got=%b exp=0", psr_if.SC_PsrWin_WinOverflow_Out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) step(C_SAVE);
    checks++;
    if (psr_if.SC_PsrWin_Cwp_Out !== 5'd5) begin
      errors++; $display("FAIL b2b_saves got=%0d exp=5", psr_if.SC_PsrWin_Cwp_Out);
    end
    for (int i = 0; i < 2; i++) begin
      step(C_SAVE, 32'h0, 8'b0001_0000);
      checks++;
      if (psr_if.SC_PsrWin_WinOverflow_Out !== 1'b1 || psr_if.SC_PsrWin_Cwp_Out !== 5'd5) begin
        errors++; $display("FAIL b2b_ovf got ovf=%b cwp=%0d exp ovf=1 cwp=5",
          psr_if.SC_PsrWin_WinOverflow_Out, psr_if.SC_PsrWin_Cwp_Out);
      end
    end
    step(6'b0);
  endtask

  task automatic test_trap_rett();
    step(C_WPSR, 32'h00A0_00A5);
    step(C_TRAP);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h00A0_00C4) begin
      errors++; $display("FAIL trap got=%h exp=00a000c4", psr_if.SC_PsrWin_Psr_Out);
    end
    step(C_RETT);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h00A0_00E5) begin
      errors++; $display("FAIL rett got=%h exp=00a000e5", psr_if.SC_PsrWin_Psr_Out);
    end
    step(C_RETT);
    checks++;
    if (psr_if.SC_PsrWin_Illegal_Out !== 1'b1 || psr_if.SC_PsrWin_Psr_Out !== 32'h00A0_00E5) begin
      errors++; $display("FAIL rett_illegal got ill=%b psr=%h exp ill=1 psr=00a000e5",
        psr_if.SC_PsrWin_Illegal_Out, psr_if.SC_PsrWin_Psr_Out);
    end
  endtask

  task automatic test_priority();
    step(C_TRAP | C_WPSR, 32'h0050_0002);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h00A0_00C4) begin
      errors++; $display("FAIL prio_trap_wpsr got=%h exp=00a000c4", psr_if.SC_PsrWin_Psr_Out);
    end
    step(C_WPSR, 32'h00A0_00A5);
    step(C_TRAP | C_WPSR | C_WICC, 32'h0050_0002, 8'h0, 4'b0011);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h0030_00C4) begin
      errors++; $display("FAIL prio_trap_icc got=%h exp=003000c4", psr_if.SC_PsrWin_Psr_Out);
    end
    step(C_WPSR, 32'h0000_0089);
    checks++;
    if (psr_if.SC_PsrWin_Illegal_Out !== 1'b1 || psr_if.SC_PsrWin_Psr_Out !== 32'h0030_00C4) begin
      errors++; $display("FAIL wpsr_bad_cwp got ill=%b psr=%h exp ill=1 psr=003000c4",
        psr_if.SC_PsrWin_Illegal_Out, psr_if.SC_PsrWin_Psr_Out);
    end
    step(C_WPSR | C_WICC, 32'h00A0_00A5, 8'h0, 4'b0011);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h00A0_00A5) begin
      errors++; $display("FAIL wpsr_beats_icc got=%h exp=00a000a5", psr_if.SC_PsrWin_Psr_Out);
    end
  endtask

  task automatic test_illegal_err();
    step(C_WPSR, 32'h0000_0000);
    step(C_WPSR, 32'h0000_0085);
    checks++;
    if (psr_if.SC_PsrWin_Illegal_Out !== 1'b1 || psr_if.SC_PsrWin_Psr_Out !== 32'h0) begin
      errors++; $display("FAIL wpsr_user got ill=%b psr=%h exp ill=1 psr=0",
        psr_if.SC_PsrWin_Illegal_Out, psr_if.SC_PsrWin_Psr_Out);
    end
    step(C_TRAP);
    checks++;
    if (psr_if.SC_PsrWin_ErrorMode_Out !== 1'b1) begin
      errors++; $display("FAIL trap_et0_err got=%b exp=1", psr_if.SC_PsrWin_ErrorMode_Out);
    end
    step(C_SAVE);
    checks++;
    if (psr_if.SC_PsrWin_Cwp_Out !== 5'd0) begin
      errors++; $display("FAIL err_save_ignored got=%0d exp=0", psr_if.SC_PsrWin_Cwp_Out);
    end
    step(C_WICC, 32'h0, 8'h0, 4'b0101);
    checks++;
    if (psr_if.SC_PsrWin_Psr_Out !== 32'h0050_0000) begin
      errors++; $display("FAIL err_icc_write got=%h exp=00500000", psr_if.SC_PsrWin_Psr_Out);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (psr_if.SC_PsrWin_ErrorMode_Out !== 1'b0 || psr_if.SC_PsrWin_Psr_Out !== 32'h00F0_0080) begin
      errors++; $display("FAIL midreset got err=%b psr=%h exp err=0 psr=00f00080",
        psr_if.SC_PsrWin_ErrorMode_Out, psr_if.SC_PsrWin_Psr_Out);
    end
    model_reset();
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0]  cmd;
    logic [31:0] data;
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < 6; b++) cmd[b] = ($urandom_range(0, 3) == 0);
      data = $urandom;
      data[4:0] = 5'($urandom_range(0, 9));
      step(cmd, data, 8'($urandom & $urandom), 4'($urandom));
      if (m_err && $urandom_range(0, 5) == 0) do_reset();
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_save_wrap();
    test_overflow();
    test_back_to_back();
    test_trap_rett();
    test_priority();
    test_illegal_err();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got=%0d exp=0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
